// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM state
// encoding and the power-on marker pattern.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Default sync/marker sequence loaded into the pattern register at reset.
    localparam logic [3:0] PAT_DEFAULT = 4'b1101;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left-shifting register. The MSB is the serial output; on each
// shift the vacated LSB is filled with 'fill'. Load has priority over shift.
import seq_gen_pkg::*;

module seq_gen_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    input  logic         fill,
    output logic         msb
);

    logic [W-1:0] sh_reg;

    // Shift register: load a new word or move one position towards the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_reg <= '0;
        end else if (load) begin
            sh_reg <= din;
        end else if (shift) begin
            sh_reg <= {sh_reg[W-2:0], fill};
        end
    end

    assign msb = sh_reg[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter. Latches a pattern on start and shifts it
// out MSB-first, repeating it repeat_cnt times (0 counts as 1) with an
// optional idle gap between repetitions, then pulses done.
// Optional build macro SEQ_GEN_PARITY_EN appends an even-parity bit to
// every repetition.
import seq_gen_pkg::*;

module seq_pattern_gen #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(seq_gen_pkg::PAT_DEFAULT),
    parameter int               CNT_W       = 8,
    parameter int               GAP_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int NBITS = PAT_W + 1;
`else
    localparam int NBITS = PAT_W;
`endif
    localparam int BIT_W = $clog2(NBITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

    state_t           state_reg, state_next;
    logic [BIT_W-1:0] bit_reg, bit_next;          // bits left after the current one
    logic [CNT_W-1:0] rep_reg, rep_next;          // repetitions left after the current one
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;  // gap cycles left after the current one
    logic [GAP_W-1:0] gap_len_reg, gap_len_next;
    logic [PAT_W-1:0] pat_reg, pat_next;
    logic             out_valid_reg, out_valid_next;
    logic             frame_start_reg, frame_start_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             sh_load, sh_shift, sh_fill;
    logic [PAT_W-1:0] sh_din;

    // The shifter drives out directly; loading zeros parks out at 0 in
    // GAP/DONE/IDLE so out stays a registered signal.
    seq_gen_shreg #(.W(PAT_W)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .fill  (sh_fill),
        .msb   (out)
    );

`ifdef SEQ_GEN_PARITY_EN
    // Parity fills the LSB on every shift, so it reaches the MSB exactly
    // one cycle after the pattern LSB.
    assign sh_fill = ^pat_reg;
`else
    assign sh_fill = 1'b0;
`endif

    // State, counters, latched frame parameters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            bit_reg         <= '0;
            rep_reg         <= '0;
            gap_cnt_reg     <= '0;
            gap_len_reg     <= '0;
            pat_reg         <= PAT_DEFAULT;
            out_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_reg         <= bit_next;
            rep_reg         <= rep_next;
            gap_cnt_reg     <= gap_cnt_next;
            gap_len_reg     <= gap_len_next;
            pat_reg         <= pat_next;
            out_valid_reg   <= out_valid_next;
            frame_start_reg <= frame_start_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    // Next-state and next-output logic; outputs describe the coming cycle.
    always_comb begin
        state_next       = state_reg;
        bit_next         = bit_reg;
        rep_next         = rep_reg;
        gap_cnt_next     = gap_cnt_reg;
        gap_len_next     = gap_len_reg;
        pat_next         = pat_reg;
        out_valid_next   = 1'b0;
        frame_start_next = 1'b0;
        busy_next        = 1'b0;
        done_next        = 1'b0;
        sh_load          = 1'b0;
        sh_shift         = 1'b0;
        sh_din           = '0;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next       = SEND;
                    pat_next         = pattern;
                    gap_len_next     = gap;
                    rep_next         = (repeat_cnt == '0) ? '0 : repeat_cnt - CNT_W'(1);
                    bit_next         = BIT_LAST;
                    sh_load          = 1'b1;
                    sh_din           = pattern;
                    out_valid_next   = 1'b1;
                    frame_start_next = 1'b1;
                    busy_next        = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = IDLE;
                    sh_load    = 1'b1;
                end else if (bit_reg != '0) begin
                    bit_next       = bit_reg - BIT_W'(1);
                    sh_shift       = 1'b1;
                    out_valid_next = 1'b1;
                    busy_next      = 1'b1;
                end else if (rep_reg == '0) begin
                    state_next = DONE;
                    sh_load    = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    rep_next = rep_reg - CNT_W'(1);
                    if (gap_len_reg == '0) begin
                        bit_next         = BIT_LAST;
                        sh_load          = 1'b1;
                        sh_din           = pat_reg;
                        out_valid_next   = 1'b1;
                        frame_start_next = 1'b1;
                        busy_next        = 1'b1;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = gap_len_reg - GAP_W'(1);
                        sh_load      = 1'b1;
                        busy_next    = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_cnt_reg == '0) begin
                    state_next       = SEND;
                    bit_next         = BIT_LAST;
                    sh_load          = 1'b1;
                    sh_din           = pat_reg;
                    out_valid_next   = 1'b1;
                    frame_start_next = 1'b1;
                    busy_next        = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                    busy_next    = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out_valid   = out_valid_reg;
    assign frame_start = frame_start_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule
